dac_multich_setpoint: RTL and testbench

//  Multi-channel successor of the single-value DAC setpoint counter. Holds NCH

---
 rtl/dac_pkg.sv | 20 ++
 rtl/dac_chan_reg.sv | 66 ++++++
 rtl/dac_multich_setpoint.sv | 173 +++++++++++++++++
 tb/tb_dac_multich_setpoint.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, FSM state encoding and preset switch codes for the multi-channel DAC setpoint block.
package dac_pkg;

  localparam logic [3:0] CMD_WR_UPD = 4'b0011;
  localparam logic [3:0] CMD_NOP    = 4'b1111;
  localparam logic [3:0] ADDR_ALL   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TRIG = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] SW_MAX  = 4'b1000;
  localparam logic [3:0] SW_MID  = 4'b0100;
  localparam logic [3:0] SW_ONE  = 4'b0010;
  localparam logic [3:0] SW_ZERO = 4'b0001;

endpackage

// File: rtl/dac_chan_reg.sv
// One setpoint channel: saturating up/down stepping, one-hot presets and a dirty flag
// that marks the value as not yet sent to the DAC.
module dac_chan_reg
  import dac_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int STEP  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_hit,
  input  logic [3:0]       sw,
  input  logic             rise_less,
  input  logic             rise_more,
  input  logic             clr_dirty,
  input  logic             set_dirty,
  output logic [WIDTH-1:0] value,
  output logic             dirty
);

  localparam logic [WIDTH:0] MAX_W  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] value_q, value_d;
  logic             dirty_q, dirty_d;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   up_sum;

  always_comb begin
    wide    = {1'b0, value_q};
    up_sum  = wide + STEP_W;
    value_d = value_q;
    if (sel_hit) begin
      case (sw)
        SW_MAX:  value_d = '1;
        SW_MID:  value_d = {1'b1, {(WIDTH-1){1'b0}}};
        SW_ONE:  value_d = WIDTH'(1);
        SW_ZERO: value_d = '0;
        4'b0000: begin
          if (rise_less && !rise_more) begin
            value_d = (wide < STEP_W) ? '0 : WIDTH'(wide - STEP_W);
          end else if (rise_more && !rise_less) begin
            value_d = (up_sum > MAX_W) ? '1 : up_sum[WIDTH-1:0];
          end
        end
        default: value_d = value_q;
      endcase
    end
    // A change in the same cycle as the capture keeps the channel dirty.
    dirty_d = (dirty_q && !clr_dirty) || set_dirty || (value_d != value_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      dirty_q <= 1'b1;
    end else begin
      value_q <= value_d;
      dirty_q <= dirty_d;
    end
  end

  assign value = value_q;
  assign dirty = dirty_q;

endmodule

// File: rtl/dac_multich_setpoint.sv
// NCH button-adjusted setpoints, sent round-robin to an SPI DAC driver via the
// dactrig/dacdone handshake with a no-response watchdog.
//
// state | meaning
// IDLE  | no transaction; pick next dirty channel after the last one served
// LOAD  | capture value/address of picked channel, clear its dirty flag
// TRIG  | one-cycle dactrig pulse, arm watchdog
// WAIT  | wait for dacdone; on watchdog expiry flag err and retry the channel
module dac_multich_setpoint
  import dac_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int NCH     = 4,
  parameter int STEP    = 32,
  parameter int TIMEOUT = 4096,
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             less,
  input  logic             more,
  input  logic [SEL_W-1:0] sel,
  input  logic [3:0]       sw,
  output logic [WIDTH-1:0] data,
  output logic [3:0]       address,
  output logic [3:0]       command,
  output logic             dactrig,
  input  logic             dacdone,
  output logic             busy,
  output logic             err,
  output logic [7:0]       LED
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam int NPAD = 1 << SEL_W;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       address_q, address_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             less_q, more_q;

  logic             rise_less, rise_more;
  logic             load_en, retry_en;
  logic [NCH-1:0]   sel_hit, clr_dirty, set_dirty, dirty;
  logic [WIDTH-1:0] values [NCH];
  logic [WIDTH-1:0] values_pad [NPAD];
  logic [SEL_W-1:0] pick, rr_sel;
  logic [WIDTH-1:0] sel_val;

  assign rise_less = less && !less_q;
  assign rise_more = more && !more_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign sel_hit[i]   = (sel == SEL_W'(i));
    assign clr_dirty[i] = load_en && (idx_q == SEL_W'(i));
    assign set_dirty[i] = retry_en && (idx_q == SEL_W'(i));

    dac_chan_reg #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_chan (
      .clk       (CLK50MHZ),
      .rst       (RST),
      .sel_hit   (sel_hit[i]),
      .sw        (sw),
      .rise_less (rise_less),
      .rise_more (rise_more),
      .clr_dirty (clr_dirty[i]),
      .set_dirty (set_dirty[i]),
      .value     (values[i]),
      .dirty     (dirty[i])
    );
  end

  // Pad to a power of two so sel/idx can index without range checks.
  for (genvar p = 0; p < NPAD; p++) begin : g_pad
    if (p < NCH) begin : g_real
      assign values_pad[p] = values[p];
    end else begin : g_zero
      assign values_pad[p] = '0;
    end
  end

  // Scan from farthest to nearest so the nearest dirty channel after idx_q wins.
  always_comb begin
    pick   = idx_q;
    rr_sel = '0;
    for (int k = NCH; k >= 1; k--) begin
      rr_sel = SEL_W'((int'(idx_q) + k) % NCH);
      if (dirty[rr_sel]) begin
        pick = rr_sel;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    address_d = address_q;
    err_d     = err_q;
    wd_d      = wd_q;
    load_en   = 1'b0;
    retry_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|dirty) begin
          idx_d   = pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d    = values_pad[idx_q];
        address_d = 4'(idx_q);
        load_en   = 1'b1;
        state_d   = ST_TRIG;
      end
      ST_TRIG: begin
        wd_d    = WD_W'(TIMEOUT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dacdone) begin
          state_d = ST_IDLE;
        end else if (wd_q == '0) begin
          err_d    = 1'b1;
          retry_en = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= SEL_W'(NCH - 1);
      data_q    <= '0;
      address_q <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      less_q    <= 1'b0;
      more_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      address_q <= address_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      less_q    <= less;
      more_q    <= more;
    end
  end

  assign sel_val = values_pad[sel];

  assign data    = data_q;
  assign address = address_q;
  assign command = CMD_WR_UPD;
  // Masked by RST so a reset landing on TRIG never shows a trigger.
  assign dactrig = (state_q == ST_TRIG) && !RST;
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;
  assign LED     = sel_val[WIDTH-1 -: 8];

endmodule

// File: tb/tb_dac_multich_setpoint.sv
// Directed bench for dac_multich_setpoint: reset writes, presets, saturating steps,
// round-robin order, watchdog retry and reset in mid-transaction.
module tb_dac_multich_setpoint;

  logic        CLK50MHZ = 1'b0;
  logic        RST      = 1'b1;
  logic        less     = 1'b0;
  logic        more     = 1'b0;
  logic [1:0]  sel      = 2'd0;
  logic [3:0]  sw       = 4'd0;
  logic        dacdone  = 1'b0;
  logic [11:0] data;
  logic [3:0]  address;
  logic [3:0]  command;
  logic        dactrig;
  logic        busy;
  logic        err;
  logic [7:0]  LED;

  int nvec = 0;
  int nerr = 0;
  bit resp_en = 1'b1;
  logic [3:0]  wr_addr [$];
  logic [11:0] wr_data [$];

  always #10 CLK50MHZ = ~CLK50MHZ;

  dac_multich_setpoint #(
    .WIDTH   (12),
    .NCH     (4),
    .STEP    (32),
    .TIMEOUT (20)
  ) dut (
    .CLK50MHZ (CLK50MHZ),
    .RST      (RST),
    .less     (less),
    .more     (more),
    .sel      (sel),
    .sw       (sw),
    .data     (data),
    .address  (address),
    .command  (command),
    .dactrig  (dactrig),
    .dacdone  (dacdone),
    .busy     (busy),
    .err      (err),
    .LED      (LED)
  );

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0;
    int n = 0;
    while (q < 4 && n < budget) begin
      tick();
      n++;
      if (!busy && !dactrig) q++;
      else q = 0;
    end
    chk({tag, "_quiet"}, 32'(q >= 4), 32'd1);
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int n = 0;
    while (dactrig !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_trig"}, 32'(dactrig), 32'd1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic chk_last(input string tag, input logic [3:0] a, input logic [11:0] d);
    logic [3:0]  la = 4'hx;
    logic [11:0] ld = 12'hx;
    if (wr_data.size() > 0) begin
      la = wr_addr[$];
      ld = wr_data[$];
    end
    chk({tag, "_addr"}, 32'(la), 32'(a));
    chk({tag, "_data"}, 32'(ld), 32'(d));
  endtask

  task automatic press(input logic l, input logic m);
    less = l;
    more = m;
    tick();
    less = 1'b0;
    more = 1'b0;
    tick();
  endtask

  task automatic preset(input logic [1:0] s, input logic [3:0] v);
    sel = s;
    sw  = v;
    tick();
    sw  = 4'd0;
  endtask

  // Write monitor: records every trigger with the presented address and data.
  initial begin
    forever begin
      @(posedge CLK50MHZ);
      #2;
      if (dactrig === 1'b1) begin
        wr_addr.push_back(address);
        wr_data.push_back(data);
      end
    end
  end

  // Driver model: answers each trigger 3 cycles later while enabled.
  initial begin
    forever begin
      @(posedge CLK50MHZ);
      #2;
      if (resp_en && dactrig === 1'b1) begin
        repeat (3) @(posedge CLK50MHZ);
        #2;
        dacdone = 1'b1;
        @(posedge CLK50MHZ);
        #2;
        dacdone = 1'b0;
      end
    end
  end

  initial begin
    // 1: reset state and initial rewrite of all channels with 0
    tick();
    tick();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_cmd", 32'(command), 32'h3);
    chk("rst_trig", 32'(dactrig), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    RST = 1'b0;
    wait_quiet("t1", 200);
    chk("t1_nwr", 32'(wr_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_data.size()) begin
        chk($sformatf("t1_addr%0d", i), 32'(wr_addr[i]), 32'(i));
        chk($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'h0);
      end
    end
    chk("t1_busy", 32'(busy), 32'h0);

    // 2: preset max on ch2, exact latency, then saturated more presses
    clear_log();
    sel = 2'd2;
    sw  = 4'b1000;
    tick();
    chk("t2_idle", 32'(busy), 32'h0);
    tick();
    chk("t2_load_busy", 32'(busy), 32'h1);
    chk("t2_load_trig", 32'(dactrig), 32'h0);
    tick();
    chk("t2_trig", 32'(dactrig), 32'h1);
    chk("t2_addr", 32'(address), 32'h2);
    chk("t2_data", 32'(data), 32'hFFF);
    sw = 4'd0;
    repeat (3) press(1'b0, 1'b1);
    wait_quiet("t2", 200);
    chk("t2_nwr", 32'(wr_data.size()), 32'd1);
    chk("t2_led", 32'(LED), 32'hFF);

    // 3: saturating steps on ch1
    clear_log();
    preset(2'd1, 4'b0010);
    wait_quiet("t3a", 100);
    chk_last("t3_one", 4'd1, 12'h001);
    press(1'b1, 1'b0);
    wait_quiet("t3b", 100);
    chk_last("t3_down_sat", 4'd1, 12'h000);
    preset(2'd1, 4'b0010);
    press(1'b0, 1'b1);
    wait_quiet("t3c", 100);
    chk_last("t3_up", 4'd1, 12'h021);
    preset(2'd1, 4'b0100);
    wait_quiet("t3d", 100);
    chk_last("t3_mid", 4'd1, 12'h800);
    repeat (63) press(1'b0, 1'b1);
    wait_quiet("t3e", 300);
    chk_last("t3_fe0", 4'd1, 12'hFE0);
    chk("t3_led", 32'(LED), 32'hFE);
    press(1'b0, 1'b1);
    wait_quiet("t3f", 100);
    chk_last("t3_up_sat", 4'd1, 12'hFFF);
    clear_log();
    press(1'b1, 1'b1);
    wait_quiet("t3g", 100);
    chk("t3_both_nwr", 32'(wr_data.size()), 32'd0);
    sw = 4'b0011;
    tick();
    sw = 4'd0;
    wait_quiet("t3h", 100);
    chk("t3_nonhot_nwr", 32'(wr_data.size()), 32'd0);
    chk("t3_led_hold", 32'(LED), 32'hFF);

    // 4: burst on ch0/1/3 while ch2 is in flight, ch2 changed during its WAIT
    clear_log();
    resp_en = 1'b0;
    preset(2'd2, 4'b0001);
    wait_trig("t4", 20);
    tick();
    sel = 2'd0; sw = 4'b0010; tick();
    sel = 2'd1; tick();
    sel = 2'd3; tick();
    sel = 2'd2; sw = 4'b1000; tick();
    sw = 4'd0;
    dacdone = 1'b1;
    tick();
    dacdone = 1'b0;
    resp_en = 1'b1;
    wait_quiet("t4", 200);
    chk("t4_err", 32'(err), 32'h0);
    chk("t4_nwr", 32'(wr_data.size()), 32'd5);
    if (wr_data.size() == 5) begin
      chk("t4_a0", 32'(wr_addr[0]), 32'h2); chk("t4_d0", 32'(wr_data[0]), 32'h000);
      chk("t4_a1", 32'(wr_addr[1]), 32'h3); chk("t4_d1", 32'(wr_data[1]), 32'h001);
      chk("t4_a2", 32'(wr_addr[2]), 32'h0); chk("t4_d2", 32'(wr_data[2]), 32'h001);
      chk("t4_a3", 32'(wr_addr[3]), 32'h1); chk("t4_d3", 32'(wr_data[3]), 32'h001);
      chk("t4_a4", 32'(wr_addr[4]), 32'h2); chk("t4_d4", 32'(wr_data[4]), 32'hFFF);
    end

    // 5: watchdog expiry, retry, then normal completion with sticky err
    clear_log();
    resp_en = 1'b0;
    preset(2'd0, 4'b0001);
    wait_trig("t5", 20);
    repeat (20) tick();
    chk("t5_wait_busy", 32'(busy), 32'h1);
    chk("t5_wait_err", 32'(err), 32'h0);
    tick();
    chk("t5_to_busy", 32'(busy), 32'h0);
    chk("t5_to_err", 32'(err), 32'h1);
    tick();
    resp_en = 1'b1;
    tick();
    chk("t5_retry_trig", 32'(dactrig), 32'h1);
    chk("t5_retry_addr", 32'(address), 32'h0);
    chk("t5_retry_data", 32'(data), 32'h0);
    wait_quiet("t5", 200);
    chk("t5_err_sticky", 32'(err), 32'h1);
    chk("t5_nwr", 32'(wr_data.size()), 32'd2);

    // 6: reset in TRIG, late dacdone ignored, all channels rewritten
    resp_en = 1'b0;
    preset(2'd3, 4'b1000);
    wait_trig("t6", 20);
    RST = 1'b1;
    tick();
    clear_log();
    chk("t6_trig", 32'(dactrig), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_data", 32'(data), 32'h0);
    chk("t6_addr", 32'(address), 32'h0);
    chk("t6_err", 32'(err), 32'h0);
    chk("t6_led", 32'(LED), 32'h0);
    tick();
    RST = 1'b0;
    dacdone = 1'b1;
    tick();
    dacdone = 1'b0;
    resp_en = 1'b1;
    wait_quiet("t6", 200);
    chk("t6_nwr", 32'(wr_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_data.size()) begin
        chk($sformatf("t6_addr%0d", i), 32'(wr_addr[i]), 32'(i));
        chk($sformatf("t6_data%0d", i), 32'(wr_data[i]), 32'h0);
      end
    end

    // 6b: reset during WAIT
    resp_en = 1'b0;
    preset(2'd1, 4'b1000);
    wait_trig("t6b", 20);
    tick();
    RST = 1'b1;
    tick();
    chk("t6b_busy", 32'(busy), 32'h0);
    chk("t6b_trig", 32'(dactrig), 32'h0);
    chk("t6b_data", 32'(data), 32'h0);
    RST = 1'b0;
    clear_log();
    resp_en = 1'b1;
    wait_quiet("t6b", 200);
    chk("t6b_nwr", 32'(wr_data.size()), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
